axi_lite_dummy_mem: RTL and testbench

AXI4-Lite slave memory model that consumes the AXI master driver's transactions inside the emulated DUT wrapper. It is the synthesizable target that receives AW/W/AR traffic and returns B/R responses. Storage is a word-addressed RAM with byte-strobe writes and range checking. Single clock; one write and one read in flight concurrently.

---
 rtl/axi_lite_dummy_mem.sv | 140 ++++++++++++++
 tb/tb_axi_lite_dummy_mem.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_dummy_mem.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte strobes and range checking.
// One write (AW/W buffered independently) and one read in flight at a time.
module axi_lite_dummy_mem #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUMBYTES  = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [NUMBYTES-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int unsigned LSB_W     = $clog2(NUMBYTES);
  localparam int unsigned IDX_W     = ADDR_W - LSB_W;
  localparam int unsigned MEM_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                aw_full;
  logic                w_full;
  logic [ID_W-1:0]     aw_id;
  logic [IDX_W-1:0]    aw_idx;
  logic [DATA_W-1:0]   w_data;
  logic [NUMBYTES-1:0] w_strb;

  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                ar_hs;
  logic                commit;
  logic [IDX_W-1:0]    ar_idx;
  logic                aw_in_range;
  logic                ar_in_range;
  logic                unused_addr_bits;

  assign AWREADY = !aw_full;
  assign WREADY  = !w_full;
  assign ARREADY = !RVALID || RREADY;
  assign RLAST   = RVALID;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BVALID && BREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = aw_full && w_full && !BVALID;

  assign ar_idx      = ARADDR[ADDR_W-1:LSB_W];
  assign aw_in_range = (32'(aw_idx) < MEM_WORDS);
  assign ar_in_range = (32'(ar_idx) < MEM_WORDS);

  // Sub-word address bits are ignored: unaligned accesses act as aligned.
  assign unused_addr_bits = ^{AWADDR[LSB_W-1:0], ARADDR[LSB_W-1:0]};

  // Write buffer occupancy and B channel.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        BVALID  <= 1'b1;
        BID     <= aw_id;
        BRESP   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        BVALID  <= 1'b0;
      end
      if (aw_hs) aw_full <= 1'b1;
      if (w_hs)  w_full  <= 1'b1;
    end
  end

  // Buffered AW/W payloads; only meaningful while the matching full flag is set.
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      aw_id  <= AWID;
      aw_idx <= AWADDR[ADDR_W-1:LSB_W];
    end
    if (w_hs) begin
      w_data <= WDATA;
      w_strb <= WSTRB;
    end
  end

  // RAM is never cleared; a reset edge also suppresses a commit on that edge.
  always_ff @(posedge ACLK) begin
    if (!ARESET && commit && aw_in_range) begin
      for (int i = 0; i < int'(NUMBYTES); i++) begin
        if (w_strb[i]) mem[MEM_IDX_W'(aw_idx)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // R channel; reading mem with <= returns pre-write data on a same-edge commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RVALID <= 1'b0;
      RID    <= '0;
      RRESP  <= RESP_OKAY;
      RDATA  <= '0;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RID    <= ARID;
      RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      RDATA  <= ar_in_range ? mem[MEM_IDX_W'(ar_idx)] : '0;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_dummy_mem.sv
// Bench for axi_lite_dummy_mem: directed scenarios plus randomized traffic scored
// against an array-based memory model updated on each write response.
module tb_axi_lite_dummy_mem;

  localparam int unsigned ID_W      = 4;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUMBYTES  = 4;
  localparam int unsigned MEM_WORDS = 16;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [ID_W-1:0]   AWID = '0;
  logic [ADDR_W-1:0] AWADDR = '0;
  logic              AWVALID = 1'b0;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA = '0;
  logic [3:0]        WSTRB = '0;
  logic              WVALID = 1'b0;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY = 1'b1;
  logic [ID_W-1:0]   ARID = '0;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY = 1'b1;

  always #5 ACLK = ~ACLK;

  axi_lite_dummy_mem #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUMBYTES(NUMBYTES), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct { logic [3:0] id; logic [11:0] addr; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_t;

  aw_t         aw_q[$];
  w_t          w_q[$];
  r_t          r_q[$];
  logic [31:0] ref_mem [MEM_WORDS];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aw_hs_cyc = 0;
  int w_hs_cyc = 0;
  bit rnd_rdy = 1'b0;

  logic [31:0] last_rdata = '0;
  logic [3:0]  last_rid = '0;
  logic [1:0]  last_rresp = '0;
  logic [1:0]  last_bresp = '0;

  bit          p_bstall = 1'b0;
  bit          p_rstall = 1'b0;
  bit          p_arhs = 1'b0;
  logic [3:0]  p_bid = '0;
  logic [1:0]  p_bresp = '0;
  logic [3:0]  p_rid = '0;
  logic [1:0]  p_rresp = '0;
  logic [31:0] p_rdata = '0;

  function automatic bit in_range(input logic [11:0] a);
    return a[11:2] < 10'(MEM_WORDS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge ACLK) cyc++;

  // Random backpressure on B and R while enabled.
  always @(posedge ACLK) begin
    if (rnd_rdy) begin
      #1;
      BREADY = 1'($urandom_range(0, 1));
      RREADY = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor + scoreboard, sampled mid-cycle where everything is stable.
  always @(negedge ACLK) begin : mon
    aw_t a;
    w_t  w;
    r_t  r;
    if (ARESET) begin
      aw_q.delete();
      w_q.delete();
      r_q.delete();
      p_bstall = 1'b0;
      p_rstall = 1'b0;
      p_arhs   = 1'b0;
    end else begin
      if (p_bstall) begin
        chk("b_hold_valid", 32'(BVALID), 1);
        chk("b_hold_id", 32'(BID), 32'(p_bid));
        chk("b_hold_resp", 32'(BRESP), 32'(p_bresp));
      end
      if (p_rstall) begin
        chk("r_hold_valid", 32'(RVALID), 1);
        chk("r_hold_id", 32'(RID), 32'(p_rid));
        chk("r_hold_resp", 32'(RRESP), 32'(p_rresp));
        chk("r_hold_data", RDATA, p_rdata);
      end
      if (p_arhs) chk("r_latency", 32'(RVALID), 1);
      chk("rlast", 32'(RLAST), 32'(RVALID));

      if (AWVALID && AWREADY) begin
        aw_q.push_back('{AWID, AWADDR});
        aw_hs_cyc = cyc;
      end
      if (WVALID && WREADY) begin
        w_q.push_back('{WDATA, WSTRB});
        w_hs_cyc = cyc;
      end
      if (BVALID && BREADY) begin
        chk("b_expected", 32'(aw_q.size() != 0 && w_q.size() != 0), 1);
        if (aw_q.size() != 0 && w_q.size() != 0) begin
          a = aw_q.pop_front();
          w = w_q.pop_front();
          chk("bid", 32'(BID), 32'(a.id));
          chk("bresp", 32'(BRESP), in_range(a.addr) ? 32'd0 : 32'd2);
          if (in_range(a.addr))
            for (int i = 0; i < 4; i++)
              if (w.strb[i]) ref_mem[a.addr[5:2]][8*i +: 8] = w.data[8*i +: 8];
        end
        last_bresp = BRESP;
      end
      if (ARVALID && ARREADY)
        r_q.push_back('{ARID, in_range(ARADDR) ? ref_mem[ARADDR[5:2]] : 32'd0,
                        in_range(ARADDR) ? 2'b00 : 2'b10});
      if (RVALID && RREADY) begin
        chk("r_expected", 32'(r_q.size() != 0), 1);
        if (r_q.size() != 0) begin
          r = r_q.pop_front();
          chk("rid", 32'(RID), 32'(r.id));
          chk("rdata", RDATA, r.data);
          chk("rresp", 32'(RRESP), 32'(r.resp));
        end
        last_rdata = RDATA;
        last_rid   = RID;
        last_rresp = RRESP;
      end
      p_bstall = BVALID && !BREADY;
      p_bid    = BID;
      p_bresp  = BRESP;
      p_rstall = RVALID && !RREADY;
      p_rid    = RID;
      p_rresp  = RRESP;
      p_rdata  = RDATA;
      p_arhs   = ARVALID && ARREADY;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [11:0] addr, input int dly);
    bit hs;
    int n;
    repeat (dly) tick();
    AWID = id; AWADDR = addr; AWVALID = 1'b1; n = 0;
    do begin @(negedge ACLK); hs = AWREADY; tick(); n++; end while (!hs && n < 100);
    AWVALID = 1'b0;
    if (!hs) chk("aw_timeout", 32'(hs), 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    bit hs;
    int n;
    repeat (dly) tick();
    WDATA = data; WSTRB = strb; WVALID = 1'b1; n = 0;
    do begin @(negedge ACLK); hs = WREADY; tick(); n++; end while (!hs && n < 100);
    WVALID = 1'b0;
    if (!hs) chk("w_timeout", 32'(hs), 1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [11:0] addr, input int dly);
    bit hs;
    int n;
    repeat (dly) tick();
    ARID = id; ARADDR = addr; ARVALID = 1'b1; n = 0;
    do begin @(negedge ACLK); hs = ARREADY; tick(); n++; end while (!hs && n < 100);
    ARVALID = 1'b0;
    if (!hs) chk("ar_timeout", 32'(hs), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((aw_q.size() != 0 || w_q.size() != 0 || r_q.size() != 0 || BVALID || RVALID) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 1);
  endtask

  task automatic write_one(input logic [3:0] id, input logic [11:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    fork
      send_aw(id, addr, 0);
      send_w(data, strb, 0);
    join
    wait_idle();
  endtask

  task automatic read_one(input logic [3:0] id, input logic [11:0] addr);
    send_ar(id, addr, 0);
    wait_idle();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int c;
    logic [31:0] d;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    chk("rst_awready", 32'(AWREADY), 1);
    chk("rst_wready", 32'(WREADY), 1);
    chk("rst_arready", 32'(ARREADY), 1);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_rlast", 32'(RLAST), 0);
    chk("rst_bid", 32'(BID), 0);
    chk("rst_rid", 32'(RID), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_bresp", 32'(BRESP), 0);
    chk("rst_rresp", 32'(RRESP), 0);

    // Preload every word so the model has defined contents.
    for (int k = 0; k < int'(MEM_WORDS); k++) write_one(4'(k), 12'(k * 4), $urandom, 4'hF);

    // Basic write/read with latency checks.
    fork
      send_aw(4'd3, 12'h010, 0);
      send_w(32'hDEADBEEF, 4'hF, 0);
    join
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    chk("t1_b_latency", 32'(cyc - ((aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc)), 2);
    chk("t1_bid", 32'(BID), 3);
    chk("t1_bresp", 32'(BRESP), 0);
    wait_idle();
    send_ar(4'd5, 12'h010, 0);
    chk("t1_rlast", 32'(RLAST), 1);
    wait_idle();
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_rid", 32'(last_rid), 5);
    chk("t1_rresp", 32'(last_rresp), 0);

    // Partial strobe merge.
    write_one(4'd1, 12'h020, 32'h11223344, 4'hF);
    write_one(4'd2, 12'h020, 32'hAABBCCDD, 4'h5);
    read_one(4'd4, 12'h020);
    chk("t2_rdata", last_rdata, 32'h11BB33DD);

    // W ahead of AW, B held off, second write waits for B.
    BREADY = 1'b0;
    send_w(32'h0BADF00D, 4'hF, 0);
    chk("t3_wready_low", 32'(WREADY), 0);
    tick(); tick();
    chk("t3_wready_hold", 32'(WREADY), 0);
    send_aw(4'd6, 12'h030, 0);
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    chk("t3_b_latency", 32'(cyc - aw_hs_cyc), 2);
    chk("t3_bid", 32'(BID), 6);
    fork
      send_aw(4'd9, 12'h034, 0);
      send_w(32'h76543210, 4'hF, 0);
    join
    chk("t3_awready_blocked", 32'(AWREADY), 0);
    tick(); tick();
    chk("t3_bvalid_held", 32'(BVALID), 1);
    chk("t3_bid_held", 32'(BID), 6);
    BREADY = 1'b1;
    c = cyc;
    n = 0;
    do begin tick(); n++; end while (!(BVALID && BID == 4'd9) && n < 20);
    chk("t3_second_b", 32'(cyc - c), 2);
    wait_idle();

    // Out of range: SLVERR, no aliasing into word 0.
    write_one(4'd1, 12'h040, 32'h5A5A5A5A, 4'hF);
    chk("t4_bresp", 32'(last_bresp), 2);
    read_one(4'd2, 12'h040);
    chk("t4_rdata", last_rdata, 0);
    chk("t4_rresp", 32'(last_rresp), 2);
    read_one(4'd3, 12'h000);
    chk("t4_word0", last_rdata, ref_mem[0]);

    // Back-to-back reads, then one stall cycle.
    RREADY = 1'b1;
    c = cyc;
    for (int k = 0; k < 4; k++) send_ar(4'(k), 12'(k * 4), 0);
    chk("t5_b2b", 32'(cyc - c), 4);
    ARID = 4'hA; ARADDR = 12'h014; ARVALID = 1'b1; RREADY = 1'b0;
    #1 chk("t5_arready_low", 32'(ARREADY), 0);
    d = RDATA;
    tick();
    chk("t5_rdata_held", RDATA, d);
    RREADY = 1'b1;
    #1 chk("t5_arready_high", 32'(ARREADY), 1);
    tick();
    ARVALID = 1'b0;
    wait_idle();
    chk("t5_rdata_keep", RDATA, last_rdata);

    // Reset with R pending and a full write buffered.
    RREADY = 1'b0;
    send_ar(4'd2, 12'h018, 0);
    fork
      send_aw(4'd7, 12'h018, 0);
      send_w(32'hCAFEF00D, 4'hF, 0);
    join
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("t6_rvalid", 32'(RVALID), 0);
    chk("t6_bvalid", 32'(BVALID), 0);
    chk("t6_awready", 32'(AWREADY), 1);
    chk("t6_wready", 32'(WREADY), 1);
    chk("t6_arready", 32'(ARREADY), 1);
    chk("t6_rdata", RDATA, 0);
    RREADY = 1'b1;
    read_one(4'd3, 12'h018);
    chk("t6_no_write", last_rdata, ref_mem[6]);

    // Randomized writes then reads with random backpressure.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      logic [31:0] wd;
      logic [3:0]  s;
      logic [3:0]  id;
      int          da;
      int          dw;
      a  = (k % 8 == 7) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 'h4F));
      wd = $urandom;
      s  = 4'($urandom);
      id = 4'($urandom);
      da = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      fork
        send_aw(id, a, da);
        send_w(wd, s, dw);
      join
    end
    wait_idle();
    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      a = (k % 8 == 7) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 'h4F));
      send_ar(4'($urandom), a, $urandom_range(0, 2));
    end
    wait_idle();
    rnd_rdy = 1'b0;
    tick();
    BREADY = 1'b1;
    RREADY = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
